arp_lookup_responder: RTL and testbench



---
 rtl/arp_lookup_responder_pkg.sv | 19 +
 rtl/arp_lookup_responder_if.sv | 28 ++
 rtl/arp_lookup_responder_cache_mem.sv | 71 +++++++
 rtl/arp_lookup_responder.sv | 96 +++++++++
 tb/tb_arp_lookup_responder.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arp_lookup_responder_pkg.sv
// Shared types and constants for the ARP lookup responder and its cache.
package arp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOOKUP  = 2'd1,
        ST_RESPOND = 2'd2
    } arp_state_t;

    localparam logic [31:0] BROADCAST_IP  = 32'hFFFF_FFFF;
    localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef struct packed {
        logic        valid;
        logic [31:0] ip;
        logic [47:0] mac;
    } cache_entry_t;

endpackage

// File: rtl/arp_lookup_responder_if.sv
// Request/response handshake and cache fill port of the ARP lookup responder.
interface arp_lookup_responder_if;
    logic        arp_request_valid;
    logic        arp_request_ready;
    logic [31:0] arp_request_ip;
    logic        arp_response_valid;
    logic        arp_response_ready;
    logic        arp_response_error;
    logic [47:0] arp_response_mac;
    logic        s_cache_wr_valid;
    logic        s_cache_wr_ready;
    logic [31:0] s_cache_wr_ip;
    logic [47:0] s_cache_wr_mac;

    modport master (
        output arp_request_valid, arp_request_ip, arp_response_ready,
               s_cache_wr_valid, s_cache_wr_ip, s_cache_wr_mac,
        input  arp_request_ready, arp_response_valid, arp_response_error,
               arp_response_mac, s_cache_wr_ready
    );

    modport slave (
        input  arp_request_valid, arp_request_ip, arp_response_ready,
               s_cache_wr_valid, s_cache_wr_ip, s_cache_wr_mac,
        output arp_request_ready, arp_response_valid, arp_response_error,
               arp_response_mac, s_cache_wr_ready
    );
endinterface

// File: rtl/arp_lookup_responder_cache_mem.sv
// Fully associative IP->MAC cache: parallel compare, fill/update, round-robin replace.
module arp_cache_mem
    import arp_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_ip,
    input  logic [47:0] wr_mac,
    input  logic [31:0] lookup_ip,
    output logic        lookup_hit,
    output logic [47:0] lookup_mac
);
    localparam int DEPTH = 1 << ADDR_W;

    cache_entry_t [DEPTH-1:0] entries;
    logic [ADDR_W-1:0]        rr_ptr, match_idx, free_idx;
    logic                     match_found, free_found, wr_accept;

    assign wr_ready  = !clear;
    assign wr_accept = wr_valid && !clear && (wr_ip != 32'd0);

    always_comb begin
        lookup_hit  = 1'b0;
        lookup_mac  = '0;
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].valid && entries[i].ip == lookup_ip) begin
                lookup_hit = 1'b1;
                lookup_mac = entries[i].mac;
            end
            if (entries[i].valid && entries[i].ip == wr_ip) begin
                match_found = 1'b1;
                match_idx   = ADDR_W'(i);
            end
        end
        // Descending scan leaves the lowest invalid index selected
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!entries[i].valid) begin
                free_found = 1'b1;
                free_idx   = ADDR_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries <= '0;
            rr_ptr  <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
            rr_ptr <= '0;
        end else if (wr_accept) begin
            if (match_found) begin
                entries[match_idx].mac <= wr_mac;
            end else if (free_found) begin
                entries[free_idx] <= '{valid: 1'b1, ip: wr_ip, mac: wr_mac};
            end else begin
                entries[rr_ptr] <= '{valid: 1'b1, ip: wr_ip, mac: wr_mac};
                rr_ptr          <= rr_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/arp_lookup_responder.sv
// ARP lookup responder: resolves a destination IP to a next-hop MAC (broadcast, gateway, cache).
module arp_lookup_responder
    import arp_pkg::*;
#(
    parameter int CACHE_ADDR_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    arp_lookup_responder_if.slave  bus,
    input  logic                   cache_clear,
    input  logic [31:0]            local_ip,
    input  logic [31:0]            gateway_ip,
    input  logic [31:0]            subnet_mask
);
    arp_state_t  state, state_next;
    logic        req_ready_q;
    logic [31:0] req_ip_q;
    logic [47:0] res_mac_q, resp_mac_q;
    logic        res_err_q, resp_err_q, resp_valid_q;
    logic        is_bcast, off_subnet, hit;
    logic [31:0] target_ip;
    logic [47:0] hit_mac;

    assign bus.arp_request_ready  = req_ready_q;
    assign bus.arp_response_valid = resp_valid_q;
    assign bus.arp_response_mac   = resp_mac_q;
    assign bus.arp_response_error = resp_err_q;

    always_comb begin
        is_bcast   = (req_ip_q == BROADCAST_IP) || ((req_ip_q | subnet_mask) == BROADCAST_IP);
        off_subnet = |((req_ip_q ^ local_ip) & subnet_mask);
        target_ip  = off_subnet ? gateway_ip : req_ip_q;
    end

    arp_cache_mem #(.ADDR_W(CACHE_ADDR_WIDTH)) u_cache (
        .clk        (clk),
        .rst        (rst),
        .clear      (cache_clear),
        .wr_valid   (bus.s_cache_wr_valid),
        .wr_ready   (bus.s_cache_wr_ready),
        .wr_ip      (bus.s_cache_wr_ip),
        .wr_mac     (bus.s_cache_wr_mac),
        .lookup_ip  (target_ip),
        .lookup_hit (hit),
        .lookup_mac (hit_mac)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (bus.arp_request_valid && req_ready_q) state_next = ST_LOOKUP;
            ST_LOOKUP:  state_next = ST_RESPOND;
            ST_RESPOND: if (resp_valid_q && bus.arp_response_ready) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Result is captured at the end of LOOKUP and presented one cycle later,
    // so a clear or fill after LOOKUP never disturbs the in-flight answer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready_q  <= 1'b0;
            req_ip_q     <= '0;
            res_mac_q    <= '0;
            res_err_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_mac_q   <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            req_ready_q <= (state_next == ST_IDLE);
            if (state == ST_IDLE && bus.arp_request_valid && req_ready_q)
                req_ip_q <= bus.arp_request_ip;
            if (state == ST_LOOKUP) begin
                if (is_bcast) begin
                    res_mac_q <= BROADCAST_MAC;
                    res_err_q <= 1'b0;
                end else begin
                    res_mac_q <= hit ? hit_mac : 48'd0;
                    res_err_q <= !hit;
                end
            end
            if (state == ST_RESPOND && !resp_valid_q) begin
                resp_valid_q <= 1'b1;
                resp_mac_q   <= res_mac_q;
                resp_err_q   <= res_err_q;
            end else if (resp_valid_q && bus.arp_response_ready) begin
                resp_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_arp_lookup_responder.sv
// Scoreboard bench: a behavioural cache/route model predicts each response; a monitor checks it.
module tb_arp_lookup_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cache_clear = 1'b0;
    logic [31:0] local_ip    = 32'hC0A8_010A;
    logic [31:0] gateway_ip  = 32'hC0A8_0101;
    logic [31:0] subnet_mask = 32'hFFFF_FF00;

    always #5 clk = ~clk;

    arp_lookup_responder_if bus();

    arp_lookup_responder #(.CACHE_ADDR_WIDTH(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .cache_clear (cache_clear),
        .local_ip    (local_ip),
        .gateway_ip  (gateway_ip),
        .subnet_mask (subnet_mask)
    );

    typedef struct {
        logic [47:0] mac;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          rdy_delay = 0;
    bit          m_valid[8];
    logic [31:0] m_ip[8];
    logic [47:0] m_mac[8];
    int          m_ptr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        m_ptr = 0;
    endfunction

    function automatic void model_fill(input logic [31:0] ip, input logic [47:0] mac);
        if (ip == 32'd0) return;
        for (int i = 0; i < 8; i++)
            if (m_valid[i] && m_ip[i] == ip) begin m_mac[i] = mac; return; end
        for (int i = 0; i < 8; i++)
            if (!m_valid[i]) begin m_valid[i] = 1'b1; m_ip[i] = ip; m_mac[i] = mac; return; end
        m_ip[m_ptr] = ip;
        m_mac[m_ptr] = mac;
        m_ptr = (m_ptr + 1) % 8;
    endfunction

    function automatic void model_lookup(input logic [31:0] ip, output logic [47:0] mac, output logic err);
        logic [31:0] t;
        mac = 48'd0;
        err = 1'b1;
        if (ip == 32'hFFFF_FFFF || (ip | subnet_mask) == 32'hFFFF_FFFF) begin
            mac = 48'hFFFF_FFFF_FFFF;
            err = 1'b0;
            return;
        end
        t = ((ip & subnet_mask) == (local_ip & subnet_mask)) ? ip : gateway_ip;
        for (int i = 0; i < 8; i++)
            if (m_valid[i] && m_ip[i] == t) begin mac = m_mac[i]; err = 1'b0; end
    endfunction

    // Monitor: pops an expectation on each new response, then checks it stays stable until consumed
    initial begin
        bit   in_resp;
        bit   have_exp;
        int   held;
        exp_t e;
        in_resp = 0;
        have_exp = 0;
        held = 0;
        bus.arp_response_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_resp = 0;
                bus.arp_response_ready = 1'b0;
            end else if (bus.arp_response_valid) begin
                if (!in_resp) begin
                    in_resp = 1;
                    held = 0;
                    have_exp = (exp_q.size() != 0);
                    if (!have_exp) begin
                        chk("unexpected_resp", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_mac", bus.arp_response_mac, e.mac);
                        chk("resp_err", bus.arp_response_error, e.err);
                        chk("latency", cyc - e.acc, 2);
                    end
                end else if (have_exp) begin
                    chk("hold_mac", bus.arp_response_mac, e.mac);
                    chk("hold_err", bus.arp_response_error, e.err);
                end
                chk("req_ready_low", bus.arp_request_ready, 0);
                bus.arp_response_ready = (held >= rdy_delay);
                held++;
            end else begin
                in_resp = 0;
                bus.arp_response_ready = 1'b0;
            end
        end
    end

    task automatic fill(input logic [31:0] ip, input logic [47:0] mac);
        int n = 0;
        bus.s_cache_wr_valid = 1'b1;
        bus.s_cache_wr_ip = ip;
        bus.s_cache_wr_mac = mac;
        while (!bus.s_cache_wr_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            chk("wr_ready_timeout", 64'd0, 64'd1);
        end else begin
            @(posedge clk);
            model_fill(ip, mac);
            @(negedge clk);
        end
        bus.s_cache_wr_valid = 1'b0;
    endtask

    task automatic request(input logic [31:0] ip, input bit rst_in_lookup);
        int   n = 0;
        exp_t e;
        logic [47:0] m;
        logic er;
        while (!bus.arp_request_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            chk("req_ready_timeout", 64'd0, 64'd1);
            return;
        end
        bus.arp_request_valid = 1'b1;
        bus.arp_request_ip = ip;
        @(posedge clk);
        #1;
        model_lookup(ip, m, er);
        e.mac = m;
        e.err = er;
        e.acc = cyc;
        exp_q.push_back(e);
        bus.arp_request_valid = 1'b0;
        if (rst_in_lookup) begin
            rst = 1'b1;
            #1;
            chk("rst_req_ready", bus.arp_request_ready, 0);
            chk("rst_resp_valid", bus.arp_response_valid, 0);
            chk("rst_resp_mac", bus.arp_response_mac, 0);
            chk("rst_resp_err", bus.arp_response_error, 0);
            exp_q.delete();
            model_clear();
            @(negedge clk);
            rst = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_clear();
        cache_clear = 1'b1;
        #1;
        chk("wr_ready_clear", bus.s_cache_wr_ready, 0);
        @(negedge clk);
        cache_clear = 1'b0;
        model_clear();
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.arp_response_valid) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("drain_timeout", exp_q.size(), 0);
    endtask

    function automatic logic [31:0] pool_ip(input int k);
        logic [31:0] base;
        base = 32'hC0A8_0100;
        return (k == 0) ? base + 32'd1 : base + 32'd19 + 32'(k);
    endfunction

    initial begin
        int n;
        bus.arp_request_valid = 1'b0;
        bus.arp_request_ip = '0;
        bus.s_cache_wr_valid = 1'b0;
        bus.s_cache_wr_ip = '0;
        bus.s_cache_wr_mac = '0;
        model_clear();
        #12;
        chk("reset_req_ready", bus.arp_request_ready, 0);
        chk("reset_resp_valid", bus.arp_response_valid, 0);
        chk("reset_resp_err", bus.arp_response_error, 0);
        chk("reset_resp_mac", bus.arp_response_mac, 0);
        chk("reset_wr_ready", bus.s_cache_wr_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", bus.arp_request_ready, 1);

        // Basic hit on the local subnet
        fill(32'hC0A8_0114, 48'h0200_0000_0014);
        request(32'hC0A8_0114, 0);
        drain();

        // Limited and directed broadcast with an empty cache
        do_clear();
        request(32'hFFFF_FFFF, 0);
        request(32'hC0A8_01FF, 0);
        drain();

        // Off-subnet via gateway, then without the gateway entry
        fill(32'hC0A8_0101, 48'h0200_0000_0001);
        request(32'h0A00_0005, 0);
        drain();
        do_clear();
        request(32'h0A00_0005, 0);
        drain();

        // Nine fills into eight entries, then refill of an existing IP
        for (int i = 0; i < 9; i++) fill(32'hC0A8_0164 + 32'(i), 48'h0200_0000_0100 + 48'(i));
        request(32'hC0A8_0164, 0);
        request(32'hC0A8_016C, 0);
        fill(32'hC0A8_0166, 48'h0200_0000_0BEE);
        request(32'hC0A8_0166, 0);
        request(32'hC0A8_0165, 0);
        drain();

        // Back-pressure on the response, clear while it is held
        fill(32'hC0A8_0114, 48'h0200_0000_0014);
        rdy_delay = 5;
        request(32'hC0A8_0114, 0);
        n = 0;
        while (!bus.arp_response_valid && n < 20) begin @(negedge clk); n++; end
        chk("resp_seen", bus.arp_response_valid, 1);
        do_clear();
        drain();
        rdy_delay = 0;
        request(32'hC0A8_0114, 0);
        drain();

        // Reset while a lookup is in flight
        fill(32'hC0A8_011E, 48'h0200_0000_001E);
        request(32'hC0A8_011E, 1);
        request(32'hC0A8_011E, 0);
        drain();

        // Randomized mix of fills, requests and clears
        for (int it = 0; it < 120; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                fill(($urandom_range(0, 15) == 0) ? 32'd0 : pool_ip($urandom_range(0, 10)),
                     {16'h0200, 32'($urandom)});
            end else if (r <= 8) begin
                int k;
                logic [31:0] ip;
                k = $urandom_range(0, 5);
                case (k)
                    0: ip = 32'hFFFF_FFFF;
                    1: ip = 32'hC0A8_01FF;
                    2: ip = {8'd10, 24'($urandom)};
                    default: ip = pool_ip($urandom_range(0, 10));
                endcase
                rdy_delay = $urandom_range(0, 3);
                request(ip, 0);
            end else begin
                do_clear();
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
